// File: rtl/maze_rom_server_if.sv
// Maze ROM read bus: controller port, renderer request/response, ROM port and conflict count.
// The server takes the slave modport; initiators and the ROM model take the master modport.
interface maze_rom_server_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic              i_ctrl_en;
  logic [ADDR_W-1:0] i_ctrl_addr;
  logic [DATA_W-1:0] o_ctrl_data;
  logic              i_rd_req_valid;
  logic              o_rd_req_ready;
  logic [ADDR_W-1:0] i_rd_req_addr;
  logic              o_rd_rsp_valid;
  logic [DATA_W-1:0] o_rd_rsp_data;
  logic              i_rd_rsp_ready;
  logic              o_rom_en;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic [15:0]       o_conflict_cnt;

  modport slave (
    input  i_ctrl_en, i_ctrl_addr, i_rd_req_valid, i_rd_req_addr, i_rd_rsp_ready, i_rom_data,
    output o_ctrl_data, o_rd_req_ready, o_rd_rsp_valid, o_rd_rsp_data, o_rom_en, o_rom_addr,
           o_conflict_cnt
  );

  modport master (
    output i_ctrl_en, i_ctrl_addr, i_rd_req_valid, i_rd_req_addr, i_rd_rsp_ready, i_rom_data,
    input  o_ctrl_data, o_rd_req_ready, o_rd_rsp_valid, o_rd_rsp_data, o_rom_en, o_rom_addr,
           o_conflict_cnt
  );
endinterface

// File: rtl/maze_rom_server.sv
// Single-port maze ROM arbiter: the controller always wins with fixed 1-cycle latency, and
// renderer reads are queued in a 2-entry response FIFO.
module maze_rom_server #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  maze_rom_server_if.slave bus
);
  localparam logic [1:0] OwnNone = 2'd0;
  localparam logic [1:0] OwnCtrl = 2'd1;
  localparam logic [1:0] OwnRd   = 2'd2;
  localparam logic [2:0] Depth   = 3'(FIFO_DEPTH);

  logic [1:0]        owner_q, owner_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [15:0]       conflict_q, conflict_d;

  logic              push, pop, req_ready, rom_en;
  logic [ADDR_W-1:0] rom_addr;

  always_comb begin
    push      = (owner_q == OwnRd);
    pop       = (cnt_q != 2'd0) && bus.i_rd_rsp_ready;
    req_ready = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    owner_d   = OwnNone;
    if (bus.i_ctrl_en) begin
      rom_en   = 1'b1;
      rom_addr = bus.i_ctrl_addr;
      owner_d  = OwnCtrl;
    end else begin
      // A same-cycle pop frees a slot, so a streaming renderer never sees a bubble.
      req_ready = ({1'b0, cnt_q} + {2'b00, push}) < (Depth + {2'b00, pop});
      if (bus.i_rd_req_valid && req_ready) begin
        rom_en   = 1'b1;
        rom_addr = bus.i_rd_req_addr;
        owner_d  = OwnRd;
      end
    end
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = bus.i_rom_data;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};

    hold_d = (owner_q == OwnCtrl) ? bus.i_rom_data : hold_q;

    conflict_d = conflict_q;
    if (bus.i_ctrl_en && bus.i_rd_req_valid && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OwnNone;
      hold_q     <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      conflict_q <= 16'd0;
    end else begin
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.o_ctrl_data    = hold_d;
  assign bus.o_rd_req_ready = req_ready;
  assign bus.o_rd_rsp_valid = (cnt_q != 2'd0);
  assign bus.o_rd_rsp_data  = fifo_q[rd_ptr_q];
  assign bus.o_rom_en       = rom_en;
  assign bus.o_rom_addr     = rom_addr;
  assign bus.o_conflict_cnt = conflict_q;
endmodule

// File: tb/tb_maze_rom_server.sv
// Directed bench for maze_rom_server: registered ROM model, response monitor, hand-computed
// expectations for controller, renderer, collision, backpressure, reset and saturation cases.
module tb_maze_rom_server;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_rom_server_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  maze_rom_server #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rom_mem [2**AW];
  logic [DW-1:0] rom_q;
  always_ff @(posedge clk) begin
    if (bus.o_rom_en) rom_q <= rom_mem[bus.o_rom_addr];
  end
  assign bus.i_rom_data = rom_q;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] rsp_q [$];
  int            rsp_cyc_q [$];
  always @(negedge clk) begin
    #4;
    if (bus.o_rd_rsp_valid && bus.i_rd_rsp_ready) begin
      rsp_q.push_back(bus.o_rd_rsp_data);
      rsp_cyc_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    #3;
    if (!rst && dut.push && dut.cnt_q == 2'd2) check_eq("fifo_no_overflow", 32'(dut.pop), 32'd1);
  end

  task automatic wait_rsp(input int n);
    int b = 0;
    while (rsp_q.size() < n && b < 30) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic clear_rsp();
    rsp_q.delete();
    rsp_cyc_q.delete();
  endtask

  int acc0;
  int acc;
  int idx;
  int budget;

  initial begin
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = 16'(i + 32'h100);
    rom_mem[11'h021] = 16'hFFFF;
    rom_mem[11'h030] = 16'h0000;
    rom_mem[11'h040] = 16'hBEEF;
    bus.i_ctrl_en      = 1'b0;
    bus.i_ctrl_addr    = '0;
    bus.i_rd_req_valid = 1'b0;
    bus.i_rd_req_addr  = '0;
    bus.i_rd_rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_rsp_valid", 32'(bus.o_rd_rsp_valid), 32'd0);
    check_eq("rst_conflict", 32'(bus.o_conflict_cnt), 32'd0);
    check_eq("rst_ctrl_data", 32'(bus.o_ctrl_data), 32'd0);
    check_eq("rst_rom_en", 32'(bus.o_rom_en), 32'd0);
    check_eq("rst_rom_addr", 32'(bus.o_rom_addr), 32'd0);
    check_eq("rst_req_ready", 32'(bus.o_rd_req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Controller read, hold, then a wall
    @(negedge clk);
    bus.i_ctrl_en = 1'b1; bus.i_ctrl_addr = 11'h021;
    #1;
    check_eq("ctrl_rom_en", 32'(bus.o_rom_en), 32'd1);
    check_eq("ctrl_rom_addr", 32'(bus.o_rom_addr), 32'h021);
    check_eq("ctrl_req_ready", 32'(bus.o_rd_req_ready), 32'd0);
    @(negedge clk);
    bus.i_ctrl_en = 1'b0;
    #1;
    check_eq("ctrl_data", 32'(bus.o_ctrl_data), 32'hFFFF);
    check_eq("ctrl_idle_rom_en", 32'(bus.o_rom_en), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    check_eq("ctrl_data_held", 32'(bus.o_ctrl_data), 32'hFFFF);
    @(negedge clk);
    bus.i_ctrl_en = 1'b1; bus.i_ctrl_addr = 11'h030;
    @(negedge clk);
    bus.i_ctrl_en = 1'b0;
    #1;
    check_eq("ctrl_wall", 32'(bus.o_ctrl_data), 32'h0000);

    // Renderer stream, one accept per cycle
    clear_rsp();
    bus.i_rd_rsp_ready = 1'b1;
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'(i);
      #1;
      check_eq("stream_ready", 32'(bus.o_rd_req_ready), 32'd1);
      if (i == 0) acc0 = cyc;
    end
    @(negedge clk);
    bus.i_rd_req_valid = 1'b0;
    wait_rsp(4);
    check_eq("stream_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < rsp_q.size(); i++) begin
      check_eq("stream_data", 32'(rsp_q[i]), 32'(32'h100 + i));
      check_eq("stream_cycle", 32'(rsp_cyc_q[i]), 32'(acc0 + 2 + i));
    end

    // Collision: controller wins, renderer follows next cycle
    clear_rsp();
    @(negedge clk);
    bus.i_ctrl_en = 1'b1; bus.i_ctrl_addr = 11'h040;
    bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'h005;
    #1;
    check_eq("coll_req_ready", 32'(bus.o_rd_req_ready), 32'd0);
    check_eq("coll_rom_addr", 32'(bus.o_rom_addr), 32'h040);
    @(negedge clk);
    bus.i_ctrl_en = 1'b0;
    #1;
    check_eq("coll_rd_ready", 32'(bus.o_rd_req_ready), 32'd1);
    check_eq("coll_rd_addr", 32'(bus.o_rom_addr), 32'h005);
    check_eq("coll_ctrl_data", 32'(bus.o_ctrl_data), 32'hBEEF);
    check_eq("coll_count", 32'(bus.o_conflict_cnt), 32'd1);
    @(negedge clk);
    bus.i_rd_req_valid = 1'b0;
    wait_rsp(1);
    check_eq("coll_rsp_count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) check_eq("coll_rsp_data", 32'(rsp_q[0]), 32'h105);

    // Backpressure: only two accepted while responses are blocked
    clear_rsp();
    bus.i_rd_rsp_ready = 1'b0;
    acc = 0;
    idx = 0;
    repeat (6) begin
      @(negedge clk);
      bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'(32'h10 + idx);
      #1;
      if (bus.o_rd_req_ready) begin
        acc++;
        idx++;
      end
    end
    check_eq("bp_accepted", 32'(acc), 32'd2);
    check_eq("bp_ready_low", 32'(bus.o_rd_req_ready), 32'd0);
    check_eq("bp_rsp_valid", 32'(bus.o_rd_rsp_valid), 32'd1);
    check_eq("bp_head", 32'(bus.o_rd_rsp_data), 32'h110);
    @(negedge clk);
    #1;
    check_eq("bp_head_stable", 32'(bus.o_rd_rsp_data), 32'h110);
    check_eq("bp_ready_still_low", 32'(bus.o_rd_req_ready), 32'd0);
    budget = 0;
    while (idx < 4 && budget < 10) begin
      @(negedge clk);
      bus.i_rd_rsp_ready = 1'b1;
      bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'(32'h10 + idx);
      #1;
      if (bus.o_rd_req_ready) idx++;
      budget++;
    end
    @(negedge clk);
    bus.i_rd_req_valid = 1'b0;
    check_eq("bp_all_accepted", 32'(idx), 32'd4);
    wait_rsp(4);
    check_eq("bp_rsp_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < rsp_q.size(); i++) begin
      check_eq("bp_rsp_data", 32'(rsp_q[i]), 32'(32'h110 + i));
    end

    // Reset with one entry queued and one read in flight
    clear_rsp();
    bus.i_rd_rsp_ready = 1'b0;
    @(negedge clk);
    bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'h007;
    #1;
    check_eq("mr_accept0", 32'(bus.o_rd_req_ready), 32'd1);
    @(negedge clk);
    bus.i_rd_req_addr = 11'h008;
    #1;
    check_eq("mr_accept1", 32'(bus.o_rd_req_ready), 32'd1);
    @(negedge clk);
    bus.i_rd_req_valid = 1'b0;
    #1;
    check_eq("mr_pre_valid", 32'(bus.o_rd_rsp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_rsp_valid", 32'(bus.o_rd_rsp_valid), 32'd0);
    check_eq("mr_conflict", 32'(bus.o_conflict_cnt), 32'd0);
    check_eq("mr_ctrl_data", 32'(bus.o_ctrl_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_rd_rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check_eq("mr_no_stale", 32'(bus.o_rd_rsp_valid), 32'd0);
    end
    check_eq("mr_rsp_count", 32'(rsp_q.size()), 32'd0);
    check_eq("mr_ready", 32'(bus.o_rd_req_ready), 32'd1);

    // Conflict counter saturation
    @(negedge clk);
    bus.i_ctrl_en = 1'b1; bus.i_ctrl_addr = 11'h000;
    bus.i_rd_req_valid = 1'b1; bus.i_rd_req_addr = 11'h001;
    repeat (65534) @(negedge clk);
    #1;
    check_eq("sat_fffe", 32'(bus.o_conflict_cnt), 32'hFFFE);
    repeat (70000 - 65534) @(negedge clk);
    #1;
    check_eq("sat_ffff", 32'(bus.o_conflict_cnt), 32'hFFFF);
    bus.i_ctrl_en = 1'b0;
    bus.i_rd_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("sat_hold", 32'(bus.o_conflict_cnt), 32'hFFFF);
    check_eq("sat_ready", 32'(bus.o_rd_req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
